gpr_file: RTL and testbench
===========================

# gpr_file

General-purpose register file that sits at the far end of the writeback stage: it consumes the registered writeback triple (data, destination, 4-bit byte strobe) and commits it into 32×32-bit architectural registers. It also serves the decode stage with two combinational read ports and a per-register pending-write scoreboard, so decode can stall on RAW hazards. Register 0 always reads 0 and is never written or tracked.

## Interface
Parameters:
- NREG, 32, number of architectural registers (index width 5).
- CNT_W, 2, width of each scoreboard pending counter (max 2^CNT_W−1 in-flight writes per register).

Ports:
- clk  input  1  clock; all state updates on posedge.
- resetn  input  1  synchronous, active-low reset.
- wb_data  input  32  writeback data.
- wb_dst  input  5  writeback destination register.
- wb_strobe  input  4  byte write strobe; bit i enables byte i (bits 8i+7:8i).
- ra1, ra2  input  5  read addresses.
- rd1, rd2  output  32  read data (combinational).
- rd1_busy, rd2_busy  output  1  register at ra1/ra2 has a pending write outstanding.
- iss_valid  input  1  decode issues an instruction that will write iss_dst.
- iss_dst  input  5  destination of the issuing instruction.
- iss_ready  output  1  issue accepted this cycle (combinational).
- sb_err  output  1  sticky scoreboard underflow flag.

## Operation
- Storage: regs[1..31], 32 bits each; regs[0] not implemented, reads as 0.
- Write commit: when wb_strobe != 0 and wb_dst != 0, at posedge regs[wb_dst] byte i ← wb_data byte i for every set strobe bit i; other bytes keep old value. wb_dst == 0 or wb_strobe == 0: no write.
- Retire event: same condition as write commit (wb_strobe != 0 and wb_dst != 0).
- Scoreboard: cnt[r], CNT_W bits, r = 1..31.
  - Issue event: iss_valid && iss_ready && iss_dst != 0.
  - iss_ready = 0 iff iss_valid, iss_dst != 0 and cnt[iss_dst] == max and no retire to iss_dst this cycle; otherwise 1. iss_dst == 0 is always ready and changes nothing.
  - Per register each cycle: issue only → cnt+1; retire only → cnt−1; both → unchanged.
  - Retire with cnt == 0 and no simultaneous issue to same reg: cnt stays 0, sb_err ← 1 (sticky until reset). Write data still commits.
- Busy: rdN_busy = (cnt[raN] != 0); raN == 0 → 0. Issue in the current cycle does not affect busy until the next cycle.
- Reads: rdN = regs[raN] (0 for raN == 0), subject to bypass rule under Configuration.

## Timing
- Reset (resetn low at posedge): all regs ← 0, all cnt ← 0, sb_err ← 0. Outputs after reset: rd1 = rd2 = 0, rd*_busy = 0, iss_ready = 1, sb_err = 0. Reset overrides any same-cycle write, issue or retire.
- Write latency: data visible on rdN from the cycle after the commit posedge (without bypass).
- Scoreboard latency: counter change visible on busy/iss_ready the cycle after the event.
- iss_ready and rdN are combinational from current inputs and state; no cycle registration.
- Full boundary: cnt == max and retire to same reg in same cycle → issue accepted, count unchanged.

## Configuration
- Macro GPR_FILE_BYPASS_EN.
- Defined: when a write commit targets raN in the current cycle, rdN returns the byte-merged value (strobed bytes from wb_data, others from regs); rdN_busy additionally reports 0 when cnt[raN] == 1 and a retire to raN occurs this cycle (and no issue to it).
- Undefined: rdN always returns stored regs value; busy strictly cnt != 0. Same-cycle readers see old data and must wait one cycle.

## Test plan
- Reset then read all 32 regs → all 0, busy 0, iss_ready 1, sb_err 0.
- Write wb_dst=5, data 0xAABBCCDD, strobe 4'b1111; next cycle strobe 4'b0010, data 0x00001100 → regs[5] = 0xAABB11DD; with bypass, ra1=5 in the second cycle reads 0xAABB11DD combinationally, without bypass 0xAABBCCDD.
- Write wb_dst=0, strobe 4'b1111, data 0xFFFFFFFF → ra1=0 reads 0; issue iss_dst=0 → iss_ready 1, no busy change.
- Issue to r7 three times (CNT_W=2) → rd1_busy=1 with ra1=7; fourth issue → iss_ready 0; fourth issue plus retire r7 same cycle → iss_ready 1, cnt stays 3; three more retires → busy 0.
- Retire r9 with cnt[9]=0 → sb_err 1 next cycle, regs[9] updated, stays 1 until resetn low.
- Reset asserted mid-stream with cnt[3]=2 and a same-cycle write to r3 → next cycle regs[3]=0, busy 0, sb_err 0.

Source files
------------

// File: rtl/gpr_file.sv
// gpr_file: 32x32 general-purpose register file with a writeback commit port,
// two combinational decode read ports and a per-register pending-write
// scoreboard for RAW hazard stalls. Register 0 reads 0, is never written and
// never tracked.
//
// Optional feature: define GPR_FILE_BYPASS_EN to forward the same-cycle
// writeback (byte-merged) onto rd1/rd2 and to clear busy early when the last
// outstanding write to a read register retires this cycle.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   wb_data/wb_dst/wb_strobe  writeback triple; commit + retire when
//                          wb_strobe != 0 and wb_dst != 0
//   ra1/ra2 -> rd1/rd2     combinational read data
//   rd1_busy/rd2_busy      read register has a pending write outstanding
//   iss_valid/iss_dst      decode issues an instruction writing iss_dst
//   iss_ready              issue accepted this cycle (combinational)
//   sb_err                 sticky scoreboard underflow flag

// One architectural register plus its pending-write counter.
module gpr_slot #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [3:0]       wr_strobe,   // already qualified by the write target
   input  logic [31:0]      wb_data,
   input  logic             inc,
   input  logic             dec,
   output logic [31:0]      q,
   output logic [CNT_W-1:0] cnt,
   output logic             uflow
);
   // A retire against an empty counter is an underflow unless a same-cycle
   // issue to this register cancels it.
   assign uflow = dec && !inc && (cnt == '0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         q <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (wr_strobe[b]) q[8*b +: 8] <= wb_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn)                          cnt <= '0;
      else if (inc && !dec)                 cnt <= cnt + 1'b1;
      else if (dec && !inc && cnt != '0)    cnt <= cnt - 1'b1;
   end
endmodule

module gpr_file #(
   parameter int NREG  = 32,
   parameter int CNT_W = 2
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [31:0]             wb_data,
   input  logic [$clog2(NREG)-1:0] wb_dst,
   input  logic [3:0]              wb_strobe,
   input  logic [$clog2(NREG)-1:0] ra1,
   input  logic [$clog2(NREG)-1:0] ra2,
   output logic [31:0]             rd1,
   output logic [31:0]             rd2,
   output logic                    rd1_busy,
   output logic                    rd2_busy,
   input  logic                    iss_valid,
   input  logic [$clog2(NREG)-1:0] iss_dst,
   output logic                    iss_ready,
   output logic                    sb_err
);
   localparam int AW = $clog2(NREG);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [NREG-1:0][31:0]      regs;
   logic [NREG-1:0][CNT_W-1:0] cnt;
   logic [NREG-1:0]            inc, dec, uflow;
   logic                       retire, issue;

   assign retire = (wb_strobe != '0) && (wb_dst != '0);

   // A full counter still accepts an issue when the same register retires
   // this cycle: the count nets to unchanged.
   assign iss_ready = !(iss_valid && (iss_dst != '0) && (cnt[iss_dst] == CNT_MAX) &&
                        !(retire && (wb_dst == iss_dst)));
   assign issue     = iss_valid && iss_ready && (iss_dst != '0);

   // Slot 0 is hardwired zero and never tracked.
   assign regs[0]  = '0;
   assign cnt[0]   = '0;
   assign inc[0]   = 1'b0;
   assign dec[0]   = 1'b0;
   assign uflow[0] = 1'b0;

   for (genvar g = 1; g < NREG; g++) begin : g_slot
      assign inc[g] = issue  && (iss_dst == AW'(g));
      assign dec[g] = retire && (wb_dst  == AW'(g));
      gpr_slot #(.CNT_W(CNT_W)) u_slot (
         .clk       (clk),
         .resetn    (resetn),
         .wr_strobe (dec[g] ? wb_strobe : 4'b0000),
         .wb_data   (wb_data),
         .inc       (inc[g]),
         .dec       (dec[g]),
         .q         (regs[g]),
         .cnt       (cnt[g]),
         .uflow     (uflow[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!resetn)     sb_err <= 1'b0;
      else if (|uflow) sb_err <= 1'b1;
   end

`ifdef GPR_FILE_BYPASS_EN
   function automatic logic [31:0] fwd(input logic [31:0] stored, input logic hit,
                                       input logic [3:0] st, input logic [31:0] d);
      logic [31:0] v;
      v = stored;
      if (hit)
         for (int b = 0; b < 4; b++)
            if (st[b]) v[8*b +: 8] = d[8*b +: 8];
      return v;
   endfunction

   // dec[] is already zero for register 0, so ra == 0 never forwards.
   assign rd1 = fwd(regs[ra1], dec[ra1], wb_strobe, wb_data);
   assign rd2 = fwd(regs[ra2], dec[ra2], wb_strobe, wb_data);

   // Busy drops early when the final outstanding write retires now.
   assign rd1_busy = (cnt[ra1] != '0) &&
                     !((cnt[ra1] == CNT_W'(1)) && dec[ra1] && !inc[ra1]);
   assign rd2_busy = (cnt[ra2] != '0) &&
                     !((cnt[ra2] == CNT_W'(1)) && dec[ra2] && !inc[ra2]);
`else
   assign rd1      = regs[ra1];
   assign rd2      = regs[ra2];
   assign rd1_busy = (cnt[ra1] != '0);
   assign rd2_busy = (cnt[ra2] != '0);
`endif
endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: randomized + directed bench for gpr_file. The driver computes
// the expected combinational outputs from an array-based model and queues
// them; a negedge monitor pops and compares against the DUT.
module tb_gpr_file;
   localparam int CMAX = 3;

   logic        clk;
   logic        resetn;
   logic [31:0] wb_data;
   logic [4:0]  wb_dst;
   logic [3:0]  wb_strobe;
   logic [4:0]  ra1, ra2;
   logic [31:0] rd1, rd2;
   logic        rd1_busy, rd2_busy;
   logic        iss_valid;
   logic [4:0]  iss_dst;
   logic        iss_ready;
   logic        sb_err;

   gpr_file #(.NREG(32), .CNT_W(2)) dut (
      .clk(clk), .resetn(resetn),
      .wb_data(wb_data), .wb_dst(wb_dst), .wb_strobe(wb_strobe),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
      .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready),
      .sb_err(sb_err)
   );

   // negedge first, so each queued expectation is checked before the posedge
   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] rd1, rd2;
      logic        b1, b2, rdy, err;
   } exp_t;

   exp_t        expq[$];
   exp_t        mon_e;
   int          n_total = 0;
   int          n_pass  = 0;

   // reference model state
   logic [31:0] mreg [32];
   int          mcnt [32];
   bit          merr;
   bit          mknown = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         mon_e = expq.pop_front();
         chk("rd1",       rd1,       mon_e.rd1);
         chk("rd2",       rd2,       mon_e.rd2);
         chk("rd1_busy",  32'(rd1_busy),  32'(mon_e.b1));
         chk("rd2_busy",  32'(rd2_busy),  32'(mon_e.b2));
         chk("iss_ready", 32'(iss_ready), 32'(mon_e.rdy));
         chk("sb_err",    32'(sb_err),    32'(mon_e.err));
      end
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] st);
      logic [31:0] v;
      v = old;
      for (int b = 0; b < 4; b++)
         if (st[b]) v = (v & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
      return v;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit ret,
                                          input logic [4:0] dst, input logic [3:0] st,
                                          input logic [31:0] d);
      if (a == 0) return 32'h0;
`ifdef GPR_FILE_BYPASS_EN
      if (ret && dst == a) return merge(mreg[a], d, st);
`endif
      return mreg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a, input bit ret, input logic [4:0] dst,
                                     input bit iss, input logic [4:0] id);
      if (a == 0) return 1'b0;
`ifdef GPR_FILE_BYPASS_EN
      if (mcnt[a] == 1 && ret && dst == a && !(iss && id == a)) return 1'b0;
`endif
      return mcnt[a] != 0;
   endfunction

   // One cycle: drive inputs, queue expected outputs, clock, advance model.
   task automatic step(input logic rn, input logic [31:0] d, input logic [4:0] dst,
                       input logic [3:0] st, input logic [4:0] a1, input logic [4:0] a2,
                       input logic iv, input logic [4:0] id);
      bit   ret, rdy, iss;
      exp_t e;
      resetn = rn; wb_data = d; wb_dst = dst; wb_strobe = st;
      ra1 = a1; ra2 = a2; iss_valid = iv; iss_dst = id;
      ret = (st != 0) && (dst != 0);
      rdy = !(iv && id != 0 && mcnt[id] == CMAX && !(ret && dst == id));
      iss = iv && rdy && (id != 0);
      e.rd1 = exp_rd(a1, ret, dst, st, d);
      e.rd2 = exp_rd(a2, ret, dst, st, d);
      e.b1  = exp_busy(a1, ret, dst, iss, id);
      e.b2  = exp_busy(a2, ret, dst, iss, id);
      e.rdy = rdy;
      e.err = merr;
      if (mknown) expq.push_back(e);
      @(posedge clk);
      if (!rn) begin
         for (int r = 0; r < 32; r++) begin mreg[r] = 0; mcnt[r] = 0; end
         merr   = 0;
         mknown = 1;
      end else begin
         if (ret) mreg[dst] = merge(mreg[dst], d, st);
         if (!(iss && ret && id == dst)) begin
            if (iss) mcnt[id]++;
            if (ret) begin
               if (mcnt[dst] == 0) merr = 1;
               else mcnt[dst]--;
            end
         end
      end
      #1;
   endtask

   task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
      step(1, 32'h0, 5'd0, 4'h0, a1, a2, 0, 5'd0);
   endtask

   initial begin
      int pend [$];
      logic [4:0] dst, id;
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // reset state, every register
      for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

      // byte-strobe merge on r5 (two issues first so retires are legal)
      step(1, 0, 0, 0, 5, 5, 1, 5);
      step(1, 0, 0, 0, 5, 5, 1, 5);
      step(1, 32'hAABBCCDD, 5, 4'b1111, 5, 5, 0, 0);
      step(1, 32'h00001100, 5, 4'b0010, 5, 6, 0, 0);
      idle(5, 0);

      // r0 never written, issue to r0 always ready
      step(1, 32'hFFFFFFFF, 0, 4'b1111, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      idle(0, 0);

      // r7 counter fill, full stall, full-with-retire, drain
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 7, 0, 1, 7);
      step(1, 0, 0, 0, 7, 0, 1, 7);
      step(1, 32'h12345678, 7, 4'b1111, 7, 0, 1, 7);
      for (int i = 0; i < 3; i++) step(1, 32'h00000011 * (i + 1), 7, 4'b0001, 7, 7, 0, 0);
      idle(7, 7);

      // underflow on r9: sticky error, data still commits
      step(1, 32'hCAFEF00D, 9, 4'b1111, 9, 0, 0, 0);
      idle(9, 0);
      idle(9, 0);

      // reset mid-stream with r3 pending and a same-cycle write to r3
      step(1, 0, 0, 0, 3, 0, 1, 3);
      step(1, 0, 0, 0, 3, 0, 1, 3);
      step(0, 32'h55555555, 3, 4'b1111, 3, 0, 1, 3);
      idle(3, 3);

      // random traffic concentrated on a few registers
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] st;
         pend.delete();
         for (int r = 1; r < 32; r++) if (mcnt[r] > 0) pend.push_back(r);
         if (pend.size() > 0 && $urandom_range(0, 4) != 0)
            dst = 5'(pend[$urandom_range(0, pend.size() - 1)]);
         else
            dst = 5'($urandom_range(0, 7));
         st = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         id = 5'($urandom_range(0, 7));
         step(($urandom_range(0, 199) != 0), $urandom, dst, st,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
              $urandom_range(0, 1) == 1, id);
      end

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
